hycontrol_ingest: RTL
=====================

HYCONTROL_INGEST -- requirements
Module: hycontrol_ingest

Interface
- REQ-001: Parameters: none; buffer depth fixed at 32 bytes, address width 5.
- REQ-002: clk  input  1  sole clock; all logic rising-edge.
- REQ-003: rst_n  input  1  synchronous, active-low reset.
- REQ-004: s_axis_tdata  input  8  incoming HY packet byte.
- REQ-005: s_axis_tvalid  input  1  byte valid.
- REQ-006: s_axis_tlast  input  1  final byte of packet.
- REQ-007: s_axis_tready  output  1  byte accepted when tvalid&tready at clk edge ("beat").
- REQ-008: buf_addr  output  5  write address to the 32x8 packet buffer.
- REQ-009: buf_dat  output  8  write data to the packet buffer.
- REQ-010: buf_write  output  1  buffer write enable; write occurs at the same clk edge as the beat.
- REQ-011: pkt_valid  output  1  complete packet held in buffer.
- REQ-012: pkt_len  output  6  byte count of held packet, 1..32; valid while pkt_valid=1.
- REQ-013: pkt_ack  input  1  downstream finished with buffer; sampled only in HOLD.
- REQ-014: overflow  output  1  one-cycle pulse when an oversize packet finishes being discarded.
- REQ-015: drop_count  output  8  saturating count of discarded oversize packets.

Function
- REQ-016: The FSM SHALL have three states: FILL, DROP, HOLD.
- REQ-017: A 5-bit write pointer wr_ptr SHALL address the buffer; buf_addr=wr_ptr, buf_dat=s_axis_tdata, buf_write=beat AND state==FILL (combinational).
- REQ-018: s_axis_tready SHALL be 1 in FILL and DROP, 0 in HOLD, and 0 whenever rst_n=0.
- REQ-019: FILL, beat, tlast=1: write byte, pkt_len<=wr_ptr+1 (6-bit), wr_ptr<=0, next state HOLD.
- REQ-020: FILL, beat, tlast=0, wr_ptr<31: write byte, wr_ptr<=wr_ptr+1, stay FILL.
- REQ-021: FILL, beat, tlast=0, wr_ptr==31: write byte, wr_ptr<=0, next state DROP (packet exceeds 32 bytes).
- REQ-022: DROP: beats accepted and discarded (no buf_write); on beat with tlast=1, overflow pulses 1 for the following cycle, drop_count increments unless at 255, next state FILL.
- REQ-023: HOLD: pkt_valid=1, no beats accepted; pkt_ack=1 -> next state FILL, pkt_valid=0 from the next cycle.
- REQ-024: pkt_valid SHALL be registered: first high in the cycle after the tlast beat, so all bytes are already in the buffer.
- REQ-025: pkt_ack outside HOLD SHALL be ignored; pkt_ack held high continuously SHALL cause exactly one HOLD cycle per packet.
- REQ-026: A packet of exactly 32 bytes (tlast on 32nd beat) SHALL be held normally with pkt_len=32.
- REQ-027: Byte ordering: byte n of a packet SHALL be written to address n (0-based).
- REQ-028: tvalid with tready=0 SHALL not change any state; tdata/tlast may change freely while tvalid=0.
- REQ-029: pkt_len SHALL retain its value after leaving HOLD until the next packet completes.

Reset
- REQ-030: On a clk edge with rst_n=0: state<=FILL, wr_ptr<=0, pkt_len<=0, pkt_valid<=0, overflow<=0, drop_count<=0.
- REQ-031: Reset mid-packet or in HOLD SHALL abandon the partial/held packet; the next beat after release is byte 0 at address 0.
- REQ-032: First cycle after rst_n returns 1: tready=1, buf_write follows tvalid.

Verification
- REQ-033: 4-byte packet 0x11,0x22,0x33,0x44 (tlast on 0x44), pkt_ack=0 -> writes addr 0..3 with those bytes, pkt_valid=1 next cycle, pkt_len=4, tready=0 until pkt_ack.
- REQ-034: 32-byte packet 0x00..0x1F, tlast on beat 32 -> addr 31 holds 0x1F, pkt_len=32, overflow never pulses.
- REQ-035: 40-byte packet, tlast on beat 40 -> buf_write only on beats 1..32, overflow one pulse after beat 40, drop_count=1, pkt_valid stays 0, next packet starts at addr 0.
- REQ-036: pkt_ack tied high, back-to-back 1-byte packets with tvalid continuously high -> each packet: 1 FILL cycle, 1 HOLD cycle, pkt_len=1, no byte lost or duplicated.
- REQ-037: rst_n low for 1 cycle after beat 3 of a 6-byte packet -> pkt_valid stays 0, drop_count=0, next beat writes addr 0.
- REQ-038: 257 consecutive 33-byte packets -> drop_count saturates at 255, overflow pulses 257 times.

Source files
------------

// File: rtl/hycontrol_ingest_if.sv
// Packet ingest bundle: AXI-Stream style byte input, packet buffer write port
// and the held-packet status/acknowledge handshake.
interface hycontrol_ingest_if;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tlast;
    logic       s_axis_tready;
    logic [4:0] buf_addr;
    logic [7:0] buf_dat;
    logic       buf_write;
    logic       pkt_valid;
    logic [5:0] pkt_len;
    logic       pkt_ack;
    logic       overflow;
    logic [7:0] drop_count;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, pkt_ack,
        input  s_axis_tready, buf_addr, buf_dat, buf_write,
        input  pkt_valid, pkt_len, overflow, drop_count
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, pkt_ack,
        output s_axis_tready, buf_addr, buf_dat, buf_write,
        output pkt_valid, pkt_len, overflow, drop_count
    );
endinterface

// File: rtl/hycontrol_ingest.sv
// Writes incoming HY packet bytes into a 32x8 buffer, holds a complete packet
// until acknowledged, and discards packets longer than the buffer.
module hycontrol_ingest (
    input  logic                clk,
    input  logic                rst_n,
    hycontrol_ingest_if.slave   bus
);
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {FILL, DROP, HOLD} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_W:0]   pkt_len_r, pkt_len_nxt;
    logic              pkt_valid_r, pkt_valid_nxt;
    logic              overflow_r, overflow_nxt;
    logic [CNT_W-1:0]  drop_count_r, drop_count_nxt;
    logic              tready;
    logic              beat;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Ready drops during reset so no beat can slip through an abandoned packet.
    assign tready = rst_n && (state != HOLD);
    assign beat   = bus.s_axis_tvalid && tready;

    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        pkt_len_nxt    = pkt_len_r;
        overflow_nxt   = 1'b0;
        drop_count_nxt = drop_count_r;
        case (state)
            FILL: begin
                if (beat) begin
                    if (bus.s_axis_tlast) begin
                        pkt_len_nxt = {1'b0, wr_ptr} + 1'b1;
                        wr_ptr_nxt  = '0;
                        state_nxt   = HOLD;
                    end else if (wr_ptr == LAST_ADDR) begin
                        wr_ptr_nxt = '0;
                        state_nxt  = DROP;
                    end else begin
                        wr_ptr_nxt = wr_ptr + 1'b1;
                    end
                end
            end
            DROP: begin
                if (beat && bus.s_axis_tlast) begin
                    overflow_nxt   = 1'b1;
                    drop_count_nxt = sat_inc(drop_count_r);
                    state_nxt      = FILL;
                end
            end
            HOLD: begin
                if (bus.pkt_ack) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
        pkt_valid_nxt = (state_nxt == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= FILL;
            wr_ptr       <= '0;
            pkt_len_r    <= '0;
            pkt_valid_r  <= 1'b0;
            overflow_r   <= 1'b0;
            drop_count_r <= '0;
        end else begin
            state        <= state_nxt;
            wr_ptr       <= wr_ptr_nxt;
            pkt_len_r    <= pkt_len_nxt;
            pkt_valid_r  <= pkt_valid_nxt;
            overflow_r   <= overflow_nxt;
            drop_count_r <= drop_count_nxt;
        end
    end

    assign bus.s_axis_tready = tready;
    assign bus.buf_addr      = wr_ptr;
    assign bus.buf_dat       = bus.s_axis_tdata;
    assign bus.buf_write     = beat && (state == FILL);
    assign bus.pkt_valid     = pkt_valid_r;
    assign bus.pkt_len       = pkt_len_r;
    assign bus.overflow      = overflow_r;
    assign bus.drop_count    = drop_count_r;
endmodule
